// File: rtl/sd_cmd_tx_pkg.sv
// sd_cmd_tx_pkg -- shared definitions for the SD command transmitter.
//   state_t      : controller FSM states
//   CRC7_POLY    : x^7 + x^3 + 1 with the implicit x^7 term dropped
//   *_BITS       : frame field widths
//   crc7_step()  : one serial CRC7 update, shared by the engine and the
//                  controller (which needs the post-update value on the
//                  edge that enters the CRC phase)
package sd_cmd_tx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BODY,
    ST_CRC,
    ST_END
  } state_t;

  localparam logic [6:0] CRC7_POLY  = 7'h09;
  localparam int         FRAME_BITS = 48;
  localparam int         BODY_BITS  = 40;
  localparam int         CRC_BITS   = 7;

  function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic din);
    logic fb;
    fb = din ^ crc[6];
    return {crc[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
  endfunction

endpackage

// File: rtl/sd_cmd_tx_crc7_ser.sv
// crc7_ser -- serial CRC7 engine, one bit per enabled cycle.
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset, clears the register
//   clr  : synchronous clear (start of a new frame), wins over en
//   en   : advance the CRC with din this cycle
//   din  : serial data bit
//   crc  : current CRC register
module crc7_ser
  import sd_cmd_tx_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       en,
  input  logic       din,
  output logic [6:0] crc
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      crc <= '0;
    end else if (en) begin
      crc <= crc7_step(crc, din);
    end
  end

endmodule

// File: rtl/sd_cmd_tx.sv
// sd_cmd_tx -- SD card command-line transmitter.
// Sends one 48-bit frame per accepted start: 0, 1, index[5:0], arg[31:0],
// CRC7[6:0], 1, MSB first, each bit held DIV clk cycles.
//   clk, rst   : clock and synchronous active-high reset
//   start      : frame request, taken only while ready=1
//   cmd_index  : 6-bit command index, captured on accept
//   cmd_arg    : 32-bit argument, captured on accept
//   ready      : idle and able to accept start
//   cmd_out    : registered serial command line (1 when idle)
//   cmd_oe     : drive enable, high for exactly the 48 frame bits
//   done       : one-cycle pulse after the end bit
//   crc_out    : CRC7 of the most recently completed frame
module sd_cmd_tx
  import sd_cmd_tx_pkg::*;
#(
  parameter int DIV = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [5:0]  cmd_index,
  input  logic [31:0] cmd_arg,
  output logic        ready,
  output logic        cmd_out,
  output logic        cmd_oe,
  output logic        done,
  output logic [6:0]  crc_out
);

  localparam logic [7:0] DIV_LAST  = 8'(DIV - 1);
  localparam logic [5:0] BODY_LAST = 6'(BODY_BITS - 1);
  localparam logic [5:0] CRC_LAST  = 6'(BODY_BITS + CRC_BITS - 1);

  state_t      state;
  logic [7:0]  div_cnt;   // cycle within the current bit
  logic [5:0]  bit_cnt;   // index of the bit on cmd_out, 0 = start bit
  logic [38:0] sh;        // bits still to send after the one on cmd_out
  logic [6:0]  crc;
  logic [6:0]  crc_next;
  logic        accept;
  logic        bit_end;

  assign accept   = start && ready;
  assign bit_end  = (div_cnt == DIV_LAST);
  // Value the CRC register takes on the edge that closes the last body bit.
  assign crc_next = crc7_step(crc, cmd_out);

  // The engine sees exactly the bit currently on the line, once per bit.
  crc7_ser u_crc (
    .clk (clk),
    .rst (rst),
    .clr (accept),
    .en  (state == ST_BODY && bit_end),
    .din (cmd_out),
    .crc (crc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      div_cnt <= '0;
      bit_cnt <= '0;
      sh      <= '0;
      ready   <= 1'b1;
      cmd_out <= 1'b1;
      cmd_oe  <= 1'b0;
      done    <= 1'b0;
      crc_out <= '0;
    end else begin
      // NOTE: non-blocking assignments here, so every branch below reads
      // the pre-edge values of state, counters and cmd_out.
      done <= 1'b0;
      if (state == ST_IDLE) begin
        if (accept) begin
          state   <= ST_BODY;
          sh      <= {1'b1, cmd_index, cmd_arg};
          cmd_out <= 1'b0;
          cmd_oe  <= 1'b1;
          ready   <= 1'b0;
          div_cnt <= '0;
          bit_cnt <= '0;
        end
      end else if (!bit_end) begin
        div_cnt <= div_cnt + 8'd1;
      end else begin
        div_cnt <= '0;
        bit_cnt <= bit_cnt + 6'd1;
        unique case (state)
          ST_BODY: begin
            if (bit_cnt == BODY_LAST) begin
              // Switch the shifter over to the finished CRC, MSB first.
              state   <= ST_CRC;
              cmd_out <= crc_next[6];
              sh      <= {crc_next[5:0], 33'd0};
            end else begin
              cmd_out <= sh[38];
              sh      <= {sh[37:0], 1'b0};
            end
          end
          ST_CRC: begin
            if (bit_cnt == CRC_LAST) begin
              state   <= ST_END;
              cmd_out <= 1'b1;
            end else begin
              cmd_out <= sh[38];
              sh      <= {sh[37:0], 1'b0};
            end
          end
          ST_END: begin
            state   <= ST_IDLE;
            cmd_out <= 1'b1;
            cmd_oe  <= 1'b0;
            ready   <= 1'b1;
            done    <= 1'b1;
            crc_out <= crc;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule
